seq_det_stim_ctrl: RTL and testbench

Controller that sequences a serial Mealy sequence-detector datapath (ports clock/reset/x/y) from a parallel pattern word. On start it pulses the detector's reset, then serializes the loaded word LSB-first onto the detector input, one bit per clock. It samples the detector's output each bit cycle, counts hits and records the first hit position, then reports done. It sits between a host or test sequencer and the detector instance, replacing hand-written per-bit stimulus loops.

---
 rtl/seq_det_stim_ctrl.sv | 136 +++++++++++++
 tb/tb_seq_det_stim_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_stim_ctrl.sv
// Stimulus controller for a serial Mealy sequence detector.
// Pulses the detector reset, shifts a pattern LSB-first and tallies hits.
module seq_det_stim_ctrl #(
  parameter int DATA_W = 20,
  parameter int CNT_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] data_in,
  input  logic              y_in,
  output logic              dut_reset,
  output logic              x_out,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  first_hit_idx,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RST   = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              dut_reset_q, dut_reset_d;
  logic              x_out_q, x_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic [CNT_W-1:0]  hit_count_q, hit_count_d;
  logic [CNT_W-1:0]  first_hit_q, first_hit_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

  // shift_q holds data >> k during SHIFT cycle k, so bit 1 is the next bit to present.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    x_out_d     = 1'b0;
    aborted_d   = aborted_q;
    hit_count_d = hit_count_q;
    first_hit_d = first_hit_q;
    bit_cnt_d   = bit_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d     = data_in;
          hit_count_d = '0;
          bit_cnt_d   = '0;
          aborted_d   = 1'b0;
          first_hit_d = CNT_ONES;
          state_d     = ST_RST;
        end
      end
      ST_RST: begin
        x_out_d = shift_q[0];
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (y_in) begin
          if (hit_count_q != CNT_ONES) begin
            hit_count_d = hit_count_q + CNT_ONE;
          end
          if (hit_count_q == '0) begin
            first_hit_d = bit_cnt_q;
          end
        end
        bit_cnt_d = bit_cnt_q + CNT_ONE;
        shift_d   = shift_q >> 1;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (bit_cnt_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          x_out_d = shift_q[1];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    dut_reset_d = (state_d == ST_RST);
    busy_d      = (state_d == ST_RST) || (state_d == ST_SHIFT);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      dut_reset_q <= 1'b0;
      x_out_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      hit_count_q <= '0;
      first_hit_q <= CNT_ONES;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      dut_reset_q <= dut_reset_d;
      x_out_q     <= x_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      hit_count_q <= hit_count_d;
      first_hit_q <= first_hit_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign dut_reset     = dut_reset_q;
  assign x_out         = x_out_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign hit_count     = hit_count_q;
  assign first_hit_idx = first_hit_q;
  assign bit_cnt       = bit_cnt_q;

endmodule

// File: tb/tb_seq_det_stim_ctrl.sv
// Randomized self-checking bench for seq_det_stim_ctrl against a pattern-level model.
// y_in is replayed from a per-bit hit vector indexed by cycles since the detector reset.
module tb_seq_det_stim_ctrl;

  localparam int DATA_W = 20;
  localparam int CNT_W  = 5;
  localparam int ONES   = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [DATA_W-1:0] data_in;
  logic              y_in;
  logic              dut_reset;
  logic              x_out;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  first_hit_idx;
  logic [CNT_W-1:0]  bit_cnt;

  logic              s_start;
  logic              s_dut_reset;
  logic              s_x_out;
  logic              s_busy;
  logic              s_done;
  logic              s_aborted;
  logic [2:0]        s_hit_count;
  logic [2:0]        s_first_hit_idx;
  logic [2:0]        s_bit_cnt;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] y_vec;
  logic              y_tie;
  logic              abort_noise;
  int                abort_idx;
  int                tb_k = 1000;

  seq_det_stim_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .data_in(data_in), .y_in(y_in), .dut_reset(dut_reset), .x_out(x_out),
    .busy(busy), .done(done), .aborted(aborted), .hit_count(hit_count),
    .first_hit_idx(first_hit_idx), .bit_cnt(bit_cnt)
  );

  // Small instance used to reach the top of the hit counter range.
  seq_det_stim_ctrl #(.DATA_W(7), .CNT_W(3)) u_sat (
    .clock(clock), .reset(reset), .start(s_start), .abort(1'b0),
    .data_in(7'h55), .y_in(1'b1), .dut_reset(s_dut_reset), .x_out(s_x_out),
    .busy(s_busy), .done(s_done), .aborted(s_aborted), .hit_count(s_hit_count),
    .first_hit_idx(s_first_hit_idx), .bit_cnt(s_bit_cnt)
  );

  always #5 clock = ~clock;

  // Bit position within the run: zero in the first cycle after the detector reset.
  always @(posedge clock) begin
    if (dut_reset) tb_k <= 0;
    else           tb_k <= tb_k + 1;
  end

  always_comb begin
    logic [DATA_W-1:0] ysh;
    ysh   = y_vec >> tb_k;
    y_in  = y_tie | ysh[0];
    abort = abort_noise | ((abort_idx >= 0) && (tb_k == abort_idx));
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic bit_at(input logic [DATA_W-1:0] v, input int k);
    logic [DATA_W-1:0] t;
    t = v >> k;
    return t[0];
  endfunction

  // Non-overlapping "101" detector expressed as a scan over the pattern.
  function automatic logic [DATA_W-1:0] detect101(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] h;
    int i;
    h = '0;
    i = 0;
    while (i <= DATA_W - 3) begin
      if (bit_at(d, i) && !bit_at(d, i + 1) && bit_at(d, i + 2)) begin
        h = h | (DATA_W'(1) << (i + 2));
        i = i + 3;
      end else begin
        i = i + 1;
      end
    end
    return h;
  endfunction

  task automatic applyStimulus(input logic [DATA_W-1:0] data, input bit spam);
    int n;
    int exp_hits;
    int exp_first;
    int exp_abort;
    n = (abort_idx >= 0) ? abort_idx + 1 : DATA_W;
    exp_abort = (abort_idx >= 0) ? 1 : 0;
    exp_hits  = 0;
    exp_first = ONES;
    for (int k = 0; k < n; k++) begin
      if (y_tie || bit_at(y_vec, k)) begin
        if (exp_first == ONES) exp_first = k;
        exp_hits++;
      end
    end
    if (exp_hits > ONES) exp_hits = ONES;

    @(negedge clock);
    data_in = data;
    start = 1'b1;
    abort_noise = 1'b0;
    @(negedge clock);
    start = 1'b0;
    data_in = DATA_W'($urandom);
    checkOutput("rst_dut_reset", 32'(dut_reset), 1);
    checkOutput("rst_busy", 32'(busy), 1);
    checkOutput("rst_x_out", 32'(x_out), 0);
    checkOutput("rst_done", 32'(done), 0);

    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      if (spam) begin
        start = 1'($urandom_range(0, 1));
        data_in = DATA_W'($urandom);
      end
      checkOutput("shift_x_out", 32'(x_out), 32'(bit_at(data, k)));
      checkOutput("shift_dut_reset", 32'(dut_reset), 0);
      checkOutput("shift_busy", 32'(busy), 1);
      checkOutput("shift_done", 32'(done), 0);
      checkOutput("shift_bit_cnt", 32'(bit_cnt), k);
    end

    @(negedge clock);
    start = spam;
    checkOutput("done_pulse", 32'(done), 1);
    checkOutput("done_busy", 32'(busy), 0);
    checkOutput("done_x_out", 32'(x_out), 0);
    checkOutput("done_dut_reset", 32'(dut_reset), 0);
    checkOutput("done_aborted", 32'(aborted), exp_abort);
    checkOutput("done_bit_cnt", 32'(bit_cnt), n);
    checkOutput("done_hit_count", 32'(hit_count), exp_hits);
    checkOutput("done_first_hit", 32'(first_hit_idx), exp_first);

    @(negedge clock);
    start = 1'b0;
    abort_noise = 1'b1;
    for (int c = 0; c < 2; c++) begin
      checkOutput("idle_done", 32'(done), 0);
      checkOutput("idle_busy", 32'(busy), 0);
      checkOutput("idle_x_out", 32'(x_out), 0);
      checkOutput("hold_hit_count", 32'(hit_count), exp_hits);
      checkOutput("hold_first_hit", 32'(first_hit_idx), exp_first);
      checkOutput("hold_bit_cnt", 32'(bit_cnt), n);
      checkOutput("hold_aborted", 32'(aborted), exp_abort);
      @(negedge clock);
    end
    abort_noise = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_dut_reset"}, 32'(dut_reset), 0);
    checkOutput({tag, "_x_out"}, 32'(x_out), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_aborted"}, 32'(aborted), 0);
    checkOutput({tag, "_hit_count"}, 32'(hit_count), 0);
    checkOutput({tag, "_first_hit"}, 32'(first_hit_idx), ONES);
    checkOutput({tag, "_bit_cnt"}, 32'(bit_cnt), 0);
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    reset = 1'b1;
    start = 1'b0;
    s_start = 1'b0;
    data_in = '0;
    y_vec = '0;
    y_tie = 1'b0;
    abort_noise = 1'b0;
    abort_idx = -1;

    repeat (2) @(negedge clock);
    checkResetValues("reset");
    reset = 1'b0;
    @(negedge clock);
    checkResetValues("post_reset");

    $display("[TB] full run driven by detector model");
    d = 20'b11101011011011011111;
    y_vec = detect101(d);
    applyStimulus(d, 1'b0);

    $display("[TB] y tied high, then low");
    y_vec = '0;
    y_tie = 1'b1;
    applyStimulus('0, 1'b0);
    y_tie = 1'b0;
    applyStimulus(DATA_W'($urandom), 1'b0);

    $display("[TB] hits in cycles 7 and 12");
    y_vec = (DATA_W'(1) << 7) | (DATA_W'(1) << 12);
    applyStimulus(DATA_W'($urandom), 1'b0);

    $display("[TB] abort in cycle 9");
    y_vec = DATA_W'(1) << 9;
    abort_idx = 9;
    applyStimulus(DATA_W'($urandom), 1'b0);
    abort_idx = -1;

    $display("[TB] start re-asserted during run");
    d = DATA_W'($urandom);
    y_vec = detect101(d);
    applyStimulus(d, 1'b1);

    $display("[TB] randomized runs");
    for (int r = 0; r < 12; r++) begin
      d = DATA_W'($urandom);
      y_tie = ($urandom_range(0, 3) == 0);
      y_vec = ($urandom_range(0, 1) == 1) ? detect101(d) : DATA_W'($urandom);
      abort_idx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DATA_W - 1)) : -1;
      applyStimulus(d, 1'($urandom_range(0, 1)));
    end
    y_tie = 1'b0;
    abort_idx = -1;

    $display("[TB] reset in SHIFT cycle 4");
    y_tie = 1'b1;
    @(negedge clock);
    data_in = DATA_W'($urandom);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    checkOutput("pre_reset_hit_count", 32'(hit_count), 4);
    #2;
    reset = 1'b1;
    #1;
    checkResetValues("async_reset");
    @(negedge clock);
    reset = 1'b0;
    y_tie = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checkOutput("after_reset_done", 32'(done), 0);
      checkOutput("after_reset_busy", 32'(busy), 0);
    end
    d = DATA_W'($urandom);
    y_vec = detect101(d);
    applyStimulus(d, 1'b0);

    $display("[TB] hit counter at full range");
    @(negedge clock);
    s_start = 1'b1;
    @(negedge clock);
    s_start = 1'b0;
    repeat (8) @(negedge clock);
    checkOutput("sat_done", 32'(s_done), 1);
    checkOutput("sat_hit_count", 32'(s_hit_count), 7);
    checkOutput("sat_first_hit", 32'(s_first_hit_idx), 0);
    checkOutput("sat_bit_cnt", 32'(s_bit_cnt), 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
